stage_fetch: RTL and testbench

- First pipeline stage; directly upstream of stage_decode.
- Holds the PC and issues in-order word fetches to the instruction memory over a request/grant + response-valid interface.
- Buffers returned words with their PCs and presents them to decode as de_valid/de_insn/de_pc, honouring de_stall.
- Takes a taken-branch/jump redirect from downstream, flushes wrong-path state, and drops in-flight wrong-path responses.

---
 rtl/stage_fetch_pkg.sv | 19 +
 rtl/stage_fetch_if.sv | 33 +++
 rtl/stage_fetch_fifo.sv | 52 +++++
 rtl/stage_fetch.sv | 110 +++++++++++
 tb/tb_stage_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package stage_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR    = 32'h0000_0000;
  localparam logic [31:0] IMEM_WORD_BYTES = 32'd4;
  localparam int          ENTRY_WIDTH     = 64;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(IMEM_WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/stage_fetch_if.sv
// Bundle of the instruction-memory, redirect and decode-facing signals of the
// fetch stage. The master side is the fetch stage itself.
interface stage_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fe_redirect;
  logic [31:0] fe_target;
  logic        de_stall;
  logic        de_valid;
  logic [31:0] de_insn;
  logic [31:0] de_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  fe_redirect, fe_target,
    input  de_stall,
    output de_valid, de_insn, de_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output fe_redirect, fe_target,
    output de_stall,
    input  de_valid, de_insn, de_pc
  );

endinterface

// File: rtl/stage_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, insn} entries. Flush wins over
// push and pop; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush and reset both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array; stale contents are never visible because empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stage_fetch.sv
// First pipeline stage: issues in-order word fetches, buffers returned words
// with their PCs, and presents them to decode. A redirect flushes the buffer
// and marks every outstanding request as wrong-path so its response is dropped.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  stage_fetch_if.master bus
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  logic [31:0]            fetch_pc;
  logic [31:0]            resp_pc;
  logic [31:0]            target_pc;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          inflight_next;
  logic [CW-1:0]          discard;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            occupancy;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   resp;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_WIDTH-1:0] push_data;
  logic [ENTRY_WIDTH-1:0] head_data;
  fetch_entry_t           head;

  // Credit: requests in flight plus buffered words never exceed DEPTH, so a
  // returning word always has a slot waiting for it.
  assign target_pc     = word_align(bus.fe_target);
  assign pop           = ~fifo_empty & ~bus.de_stall;
  assign occupancy     = {1'b0, inflight} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign bus.imem_req  = ~reset & ~bus.fe_redirect & (occupancy < DEPTH_OCC);
  assign bus.imem_addr = fetch_pc;
  assign issue         = bus.imem_req & bus.imem_gnt;
  assign resp          = bus.imem_rvalid & (inflight != '0);
  assign push          = resp & (discard == '0) & ~bus.fe_redirect;
  assign inflight_next = inflight + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, resp};
  assign push_data     = {resp_pc, bus.imem_rdata};
  assign head          = fetch_entry_t'(head_data);

  assign bus.de_valid  = ~fifo_empty;
  assign bus.de_insn   = fifo_empty ? 32'd0 : head.insn;
  assign bus.de_pc     = fifo_empty ? 32'd0 : head.pc;

  // Request and response PCs; a redirect retargets both at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (bus.fe_redirect) begin
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
    end else begin
      if (issue) fetch_pc <= fetch_pc + IMEM_WORD_BYTES;
      if (push)  resp_pc  <= resp_pc + IMEM_WORD_BYTES;
    end
  end

  // Outstanding-request bookkeeping; on redirect everything still in flight
  // after this cycle becomes wrong-path.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_next;
      if (bus.fe_redirect) begin
        discard <= inflight_next;
      end else if (resp && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.fe_redirect),
    .din   (push_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_data)
  );

`ifndef SYNTHESIS
  // Memory must not answer a request that was never issued.
  a_no_orphan_resp : assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_rvalid && (inflight == '0)));

  // The credit rule keeps the buffer from overflowing.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with a small in-order instruction memory model.
module tb_stage_fetch;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic  clk = 1'b0;
  logic  reset;
  int    errors = 0;
  int    checks = 0;
  int    mem_lat = 1;
  int    cyc = 0;
  pend_t pend_q[$];

  stage_fetch_if bus();

  stage_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: records issues at the clock edge, answers in order after
  // mem_lat cycles, forgets everything on reset.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      if (reset) pend_q.delete();
      else if (bus.imem_req && bus.imem_gnt) pend_q.push_back('{bus.imem_addr, cyc + mem_lat});
      cyc++;
      #1;
      if (!reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = insn_of(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Reset with default inputs, then return one step into cycle 0 after release.
  task automatic do_reset(input int lat);
    @(negedge clk);
    reset           = 1'b1;
    bus.imem_gnt    = 1'b1;
    bus.fe_redirect = 1'b0;
    bus.fe_target   = 32'd0;
    bus.de_stall    = 1'b0;
    mem_lat         = lat;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.imem_gnt = 1'b1; bus.fe_redirect = 1'b0; bus.fe_target = 32'd0; bus.de_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b expected 0", bus.imem_req); end
    checks++; if (bus.de_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_de_valid: got %0b expected 0", bus.de_valid); end
    checks++; if (bus.de_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_de_pc: got %h expected 0", bus.de_pc); end
    checks++; if (bus.de_insn !== 32'd0) begin errors++; $display("[TB] FAIL reset_de_insn: got %h expected 0", bus.de_insn); end
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_first_req: got req=%0b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_throughput();
    logic [31:0] exp_pc;
    $display("[TB] streaming, latency 1, no stall");
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_addr c%0d: got req=%0b addr=%h expected req=1 addr=%h", k, bus.imem_req, bus.imem_addr, 32'(4 * k)); end
      checks++; if (bus.de_valid !== (k >= 2)) begin errors++; $display("[TB] FAIL stream_valid c%0d: got %0b expected %0b", k, bus.de_valid, (k >= 2)); end
      if (k >= 2) begin
        exp_pc = 32'(4 * (k - 2));
        checks++; if (bus.de_pc !== exp_pc || bus.de_insn !== insn_of(exp_pc)) begin errors++; $display("[TB] FAIL stream_pc c%0d: got pc=%h insn=%h expected pc=%h insn=%h", k, bus.de_pc, bus.de_insn, exp_pc, insn_of(exp_pc)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic        found;
    logic [31:0] exp_pc;
    $display("[TB] decode stall at pc 0x8");
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.de_valid && bus.de_pc == 32'h8) found = 1'b1;
      else next_cycle();
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL stall_reach_pc8: got pc=%h expected 00000008 within 20 cycles", bus.de_pc); end
    bus.de_stall = 1'b1;
    for (int s = 0; s < 6; s++) begin
      next_cycle();
      checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h8 || bus.de_insn !== insn_of(32'h8)) begin errors++; $display("[TB] FAIL stall_hold s%0d: got v=%0b pc=%h insn=%h expected v=1 pc=8 insn=%h", s, bus.de_valid, bus.de_pc, bus.de_insn, insn_of(32'h8)); end
      if (s >= 1) begin
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_saturate s%0d: got req=%0b expected 0", s, bus.imem_req); end
      end
    end
    bus.de_stall = 1'b0;
    for (int j = 0; j < 8; j++) begin
      next_cycle();
      exp_pc = 32'h0C + 32'(4 * j);
      checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== exp_pc || bus.de_insn !== insn_of(exp_pc)) begin errors++; $display("[TB] FAIL stall_release j%0d: got v=%0b pc=%h expected v=1 pc=%h", j, bus.de_valid, bus.de_pc, exp_pc); end
    end
  endtask

  task automatic test_redirect_inflight();
    $display("[TB] redirect to 0x100 with two requests in flight, latency 3");
    do_reset(3);
    next_cycle();
    next_cycle();
    checks++; if (pend_q.size() != 2) begin errors++; $display("[TB] FAIL redir_inflight_pre: got %0d in flight expected 2", pend_q.size()); end
    bus.fe_redirect = 1'b1;
    bus.fe_target   = 32'h100;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_issue: got req=%0b expected 0", bus.imem_req); end
    @(negedge clk);
    bus.fe_redirect = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_target_req: got req=%0b addr=%h expected req=1 addr=00000100", bus.imem_req, bus.imem_addr); end
    for (int c = 3; c < 7; c++) begin
      checks++; if (bus.de_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop c%0d: got v=%0b pc=%h expected v=0", c, bus.de_valid, bus.de_pc); end
      next_cycle();
    end
    checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h100 || bus.de_insn !== insn_of(32'h100)) begin errors++; $display("[TB] FAIL redir_first: got v=%0b pc=%h expected v=1 pc=00000100", bus.de_valid, bus.de_pc); end
    next_cycle();
    checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h104) begin errors++; $display("[TB] FAIL redir_second: got v=%0b pc=%h expected v=1 pc=00000104", bus.de_valid, bus.de_pc); end
  endtask

  task automatic test_redirect_same_cycle();
    $display("[TB] redirect to 0x203 in the cycle a response returns");
    do_reset(1);
    next_cycle();
    checks++; if (bus.imem_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL same_cyc_pre: got rvalid=%0b expected 1", bus.imem_rvalid); end
    bus.fe_redirect = 1'b1;
    bus.fe_target   = 32'h203;
    @(negedge clk);
    bus.fe_redirect = 1'b0;
    #1;
    checks++; if (bus.de_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL same_cyc_restart: got v=%0b addr=%h expected v=0 addr=00000200", bus.de_valid, bus.imem_addr); end
    next_cycle();
    checks++; if (bus.de_valid !== 1'b0) begin errors++; $display("[TB] FAIL same_cyc_gap: got v=%0b pc=%h expected v=0", bus.de_valid, bus.de_pc); end
    next_cycle();
    checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h200 || bus.de_insn !== insn_of(32'h200)) begin errors++; $display("[TB] FAIL same_cyc_first: got v=%0b pc=%h expected v=1 pc=00000200", bus.de_valid, bus.de_pc); end
    next_cycle();
    checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h204) begin errors++; $display("[TB] FAIL same_cyc_second: got v=%0b pc=%h expected v=1 pc=00000204", bus.de_valid, bus.de_pc); end
  endtask

  task automatic test_grant_stall();
    $display("[TB] grant withheld for 5 cycles at 0x40");
    do_reset(1);
    bus.fe_redirect = 1'b1;
    bus.fe_target   = 32'h40;
    @(negedge clk);
    bus.fe_redirect = 1'b0;
    bus.imem_gnt    = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || bus.de_valid !== 1'b0) begin errors++; $display("[TB] FAIL gnt_hold g%0d: got req=%0b addr=%h v=%0b expected req=1 addr=00000040 v=0", g, bus.imem_req, bus.imem_addr, bus.de_valid); end
      next_cycle();
    end
    bus.imem_gnt = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL gnt_grant_addr: got %h expected 00000040", bus.imem_addr); end
    next_cycle();
    checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("[TB] FAIL gnt_advance: got %h expected 00000044", bus.imem_addr); end
    next_cycle();
    checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h40) begin errors++; $display("[TB] FAIL gnt_present: got v=%0b pc=%h expected v=1 pc=00000040", bus.de_valid, bus.de_pc); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] exp_pc;
    $display("[TB] reset with requests in flight and a partly full buffer");
    do_reset(3);
    bus.de_stall = 1'b1;
    repeat (5) next_cycle();
    checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== 32'h0 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midop_pre: got v=%0b pc=%h req=%0b expected v=1 pc=0 req=0", bus.de_valid, bus.de_pc, bus.imem_req); end
    reset = 1'b1;
    next_cycle();
    checks++; if (bus.de_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midop_cleared: got v=%0b req=%0b expected v=0 req=0", bus.de_valid, bus.imem_req); end
    reset        = 1'b0;
    bus.de_stall = 1'b0;
    mem_lat      = 1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midop_restart: got req=%0b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr); end
    next_cycle();
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(4 * k);
      checks++; if (bus.de_valid !== 1'b1 || bus.de_pc !== exp_pc || bus.de_insn !== insn_of(exp_pc)) begin errors++; $display("[TB] FAIL midop_seq k%0d: got v=%0b pc=%h expected v=1 pc=%h", k, bus.de_valid, bus.de_pc, exp_pc); end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.imem_gnt    = 1'b1;
    bus.fe_redirect = 1'b0;
    bus.fe_target   = 32'd0;
    bus.de_stall    = 1'b0;
    test_reset();
    test_throughput();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_grant_stall();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
